pipe_stage_buf: RTL and testbench

PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

---
 rtl/pipe_stage_buf.sv | 131 +++++++++++++
 tb/tb_pipe_stage_buf.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
// Two-entry pipeline skid buffer (main + skid register) with flush and a saturating stall counter.
// Latency: one cycle from accept to head. Backpressure: in_ready is decoded from registered state only.
// Upstream is held off only when both entries are occupied; out_ready never reaches in_ready combinationally.
module pipe_stage_buf #(
    parameter int                 PC_W         = 64,
    parameter int                 INSTR_W      = 32,
    parameter logic [INSTR_W-1:0] BUBBLE_INSTR = '0,
    parameter int                 CNT_W        = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr,
    input  logic               flush,
    output logic [CNT_W-1:0]   stall_cnt
);

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    localparam entry_t BUBBLE_ENT = {{PC_W{1'b0}}, BUBBLE_INSTR};

    state_e           state_q, state_d;
    entry_t           main_q, main_d;
    entry_t           skid_q, skid_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic   accept;
    logic   take;
    entry_t in_ent;

    assign in_ent = {in_pc, in_instr};
    assign accept = in_valid & in_ready;
    assign take   = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: if (accept) state_d = ONE;
                ONE: begin
                    if (accept && !take)      state_d = TWO;
                    else if (take && !accept) state_d = EMPTY;
                end
                TWO:     if (take) state_d = ONE;
                default: state_d = EMPTY;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state_q != TWO);
        out_valid = (state_q != EMPTY);
        out_pc    = main_q.pc;
        out_instr = main_q.instr;
        stall_cnt = stall_cnt_q;
    end

    // main is reloaded with the bubble whenever the buffer drains so EMPTY shows pc=0/BUBBLE_INSTR.
    always_comb begin
        main_d = main_q;
        skid_d = skid_q;
        if (flush) begin
            main_d = BUBBLE_ENT;
            skid_d = '0;
        end else begin
            unique case (state_q)
                EMPTY: if (accept) main_d = in_ent;
                ONE: begin
                    if (accept && take)       main_d = in_ent;
                    else if (accept)          skid_d = in_ent;
                    else if (take)            main_d = BUBBLE_ENT;
                end
                TWO: begin
                    if (take) begin
                        main_d = skid_q;
                        skid_d = '0;
                    end
                end
                default: begin
                    main_d = BUBBLE_ENT;
                    skid_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            main_q      <= BUBBLE_ENT;
            skid_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            main_q      <= main_d;
            skid_q      <= skid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: directed vector table, a saturation sequence, then random traffic
// checked against a queue-based reference model (second instance uses a 4-bit stall counter).
module tb_pipe_stage_buf;

    localparam logic [31:0] BUB = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [63:0] in_pc;
    logic [31:0] in_instr;
    logic        out_ready;
    logic        flush;

    logic        in_ready,  out_valid;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic [15:0] stall_cnt;

    logic        in_ready4, out_valid4;
    logic [63:0] out_pc4;
    logic [31:0] out_instr4;
    logic [3:0]  stall_cnt4;

    always #5 clk = ~clk;

    pipe_stage_buf #(.PC_W(64), .INSTR_W(32), .BUBBLE_INSTR(BUB), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr), .flush(flush), .stall_cnt(stall_cnt)
    );

    pipe_stage_buf #(.PC_W(64), .INSTR_W(32), .BUBBLE_INSTR(BUB), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
        .in_pc(in_pc), .in_instr(in_instr), .out_valid(out_valid4), .out_ready(out_ready),
        .out_pc(out_pc4), .out_instr(out_instr4), .flush(flush), .stall_cnt(stall_cnt4)
    );

    // Reference model: an ordered queue of at most two entries plus two saturating counters.
    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } ment_t;

    ment_t       mq[$];
    int unsigned m_sc;
    int unsigned m_sc4;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ins_of(input logic [63:0] pc);
        return pc[31:0] ^ 32'hA5A5_0000;
    endfunction

    task automatic model_edge(input logic v, input logic [63:0] pc, input logic [31:0] ins,
                              input logic ordy, input logic fl, input logic rn);
        bit    acc, tk;
        ment_t e;
        if (!rn) begin
            mq.delete();
            m_sc  = 0;
            m_sc4 = 0;
        end else begin
            acc = v && (mq.size() < 2);
            tk  = (mq.size() > 0) && ordy;
            if ((mq.size() > 0) && !ordy) begin
                if (m_sc < 65535) m_sc++;
                if (m_sc4 < 15)   m_sc4++;
            end
            if (fl) begin
                mq.delete();
            end else begin
                if (tk) void'(mq.pop_front());
                if (acc) begin
                    e.pc    = pc;
                    e.instr = ins;
                    mq.push_back(e);
                end
            end
        end
    endtask

    task automatic check_model(input string tag);
        logic [63:0] epc;
        logic [31:0] eins;
        epc  = (mq.size() > 0) ? mq[0].pc    : 64'h0;
        eins = (mq.size() > 0) ? mq[0].instr : BUB;
        chk({tag, "_in_ready"},   {63'h0, in_ready},   {63'h0, (mq.size() < 2)});
        chk({tag, "_out_valid"},  {63'h0, out_valid},  {63'h0, (mq.size() > 0)});
        chk({tag, "_out_pc"},     out_pc,              epc);
        chk({tag, "_out_instr"},  {32'h0, out_instr},  {32'h0, eins});
        chk({tag, "_stall_cnt"},  {48'h0, stall_cnt},  64'(m_sc));
        chk({tag, "_stall_cnt4"}, {60'h0, stall_cnt4}, 64'(m_sc4));
        chk({tag, "_out_pc4"},    out_pc4,             epc);
    endtask

    task automatic step(input logic v, input logic [63:0] pc, input logic [31:0] ins,
                        input logic ordy, input logic fl, input logic rn, input string tag);
        in_valid  = v;
        in_pc     = pc;
        in_instr  = ins;
        out_ready = ordy;
        flush     = fl;
        reset     = rn;
        model_edge(v, pc, ins, ordy, fl, rn);
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    typedef struct {
        logic        v;
        logic [63:0] pc;
        logic        ordy;
        logic        fl;
        logic        rn;
        logic        e_ir;
        logic        e_ov;
        logic [63:0] e_pc;
        int          e_sc;
    } vec_t;

    localparam int NV = 23;
    vec_t tbl[NV];

    function automatic vec_t mk(input logic v, input logic [63:0] pc, input logic ordy,
                                input logic fl, input logic rn, input logic e_ir,
                                input logic e_ov, input logic [63:0] e_pc, input int e_sc);
        vec_t r;
        r.v = v; r.pc = pc; r.ordy = ordy; r.fl = fl; r.rn = rn;
        r.e_ir = e_ir; r.e_ov = e_ov; r.e_pc = e_pc; r.e_sc = e_sc;
        return r;
    endfunction

    initial begin
        in_valid = 0; in_pc = '0; in_instr = '0; out_ready = 0; flush = 0; reset = 0;
        m_sc = 0; m_sc4 = 0;

        //             v  pc       ordy fl rn   ir ov pc       sc
        tbl[0]  = mk(0, 64'h0,    0,  0, 0,   1, 0, 64'h0,    0);
        // streaming
        tbl[1]  = mk(1, 64'h100,  1,  0, 1,   1, 1, 64'h100,  0);
        tbl[2]  = mk(1, 64'h104,  1,  0, 1,   1, 1, 64'h104,  0);
        tbl[3]  = mk(1, 64'h108,  1,  0, 1,   1, 1, 64'h108,  0);
        tbl[4]  = mk(0, 64'h0,    1,  0, 1,   1, 0, 64'h0,    0);
        // back-pressure: 0x208 is held upstream while full
        tbl[5]  = mk(1, 64'h200,  0,  0, 1,   1, 1, 64'h200,  0);
        tbl[6]  = mk(1, 64'h204,  0,  0, 1,   0, 1, 64'h200,  1);
        tbl[7]  = mk(1, 64'h208,  0,  0, 1,   0, 1, 64'h200,  2);
        tbl[8]  = mk(1, 64'h208,  0,  0, 1,   0, 1, 64'h200,  3);
        tbl[9]  = mk(1, 64'h208,  1,  0, 1,   1, 1, 64'h204,  3);
        tbl[10] = mk(1, 64'h208,  1,  0, 1,   1, 1, 64'h208,  3);
        tbl[11] = mk(0, 64'h0,    1,  0, 1,   1, 0, 64'h0,    3);
        // flush while full, with 0x300 offered
        tbl[12] = mk(1, 64'h2F0,  0,  0, 1,   1, 1, 64'h2F0,  3);
        tbl[13] = mk(1, 64'h2F4,  0,  0, 1,   0, 1, 64'h2F0,  4);
        tbl[14] = mk(1, 64'h300,  0,  1, 1,   1, 0, 64'h0,    5);
        tbl[15] = mk(0, 64'h0,    1,  0, 1,   1, 0, 64'h0,    5);
        // reset while full, dominating accept and take
        tbl[16] = mk(1, 64'h500,  1,  0, 1,   1, 1, 64'h500,  5);
        tbl[17] = mk(1, 64'h504,  0,  0, 1,   0, 1, 64'h500,  6);
        tbl[18] = mk(1, 64'h508,  1,  1, 0,   1, 0, 64'h0,    0);
        // simultaneous accept and take with one entry held
        tbl[19] = mk(1, 64'h400,  0,  0, 1,   1, 1, 64'h400,  0);
        tbl[20] = mk(1, 64'h404,  1,  0, 1,   1, 1, 64'h404,  0);
        tbl[21] = mk(0, 64'h0,    1,  0, 1,   1, 0, 64'h0,    0);
        tbl[22] = mk(1, 64'h600,  0,  0, 1,   1, 1, 64'h600,  0);

        for (int i = 0; i < NV; i++) begin
            string tag;
            tag = $sformatf("v%0d", i);
            step(tbl[i].v, tbl[i].pc, ins_of(tbl[i].pc), tbl[i].ordy, tbl[i].fl, tbl[i].rn, tag);
            chk({tag, "_tbl_in_ready"},  {63'h0, in_ready},  {63'h0, tbl[i].e_ir});
            chk({tag, "_tbl_out_valid"}, {63'h0, out_valid}, {63'h0, tbl[i].e_ov});
            chk({tag, "_tbl_out_pc"},    out_pc,             tbl[i].e_pc);
            chk({tag, "_tbl_out_instr"}, {32'h0, out_instr},
                {32'h0, (tbl[i].e_ov ? ins_of(tbl[i].e_pc) : BUB)});
            chk({tag, "_tbl_stall_cnt"}, {48'h0, stall_cnt}, 64'(tbl[i].e_sc));
        end

        // One entry held, downstream stalled for 20 cycles: the 4-bit counter pins at 15.
        for (int i = 0; i < 20; i++) begin
            step(0, 64'h0, 32'h0, 0, 0, 1, $sformatf("sat%0d", i));
        end
        chk("sat_cnt4_held", {60'h0, stall_cnt4}, 64'd15);
        chk("sat_cnt16",     {48'h0, stall_cnt},  64'd20);
        chk("sat_head",      out_pc,              64'h600);

        // Flush does not clear the counter.
        step(0, 64'h0, 32'h0, 0, 1, 1, "flush_keep");
        chk("flush_keeps_cnt", {48'h0, stall_cnt}, 64'd21);

        for (int i = 0; i < 3000; i++) begin
            logic        v, ordy, fl, rn;
            logic [63:0] pc;
            logic [31:0] ins;
            v    = 1'($urandom_range(0, 1));
            ordy = ($urandom_range(0, 3) != 0);
            fl   = ($urandom_range(0, 39) == 0);
            rn   = ($urandom_range(0, 99) != 0);
            pc   = {$urandom, $urandom};
            ins  = $urandom;
            step(v, pc, ins, ordy, fl, rn, "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
